sd_response: RTL and testbench

//  SD-card (SPI mode) command-response receiver. Armed by flag after a command

---
 rtl/sd_pkg.sv | 16 +
 rtl/sd_response_if.sv | 34 +++
 rtl/sd_response.sv | 76 +++++++
 tb/tb_sd_response.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI response path: receiver states and
// default R1 framing limits.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    RECEIVE,
    DONE,
    TIMEOUT
  } sd_state_t;

  localparam int R1_BITS         = 8;
  localparam int NCR_MAX_DEFAULT = 64;

endpackage

// File: rtl/sd_response_if.sv
// Bundle between the SD init/read controller (master) and the response
// receiver (slave): arm flag, card MISO line and the decoded R1 result.
interface sd_response_if
  import sd_pkg::*;
#(
  parameter int RESP_BITS = R1_BITS
);

  logic                 flag;
  logic                 response;
  logic                 receive_state;
  logic [RESP_BITS-1:0] resp_data;
  logic                 resp_valid;
  logic                 resp_timeout;

  modport master (
    output flag,
    output response,
    input  receive_state,
    input  resp_data,
    input  resp_valid,
    input  resp_timeout
  );

  modport slave (
    input  flag,
    input  response,
    output receive_state,
    output resp_data,
    output resp_valid,
    output resp_timeout
  );

endinterface

// File: rtl/sd_response.sv
// SPI-mode SD command-response receiver: waits up to NCR_MAX cycles for the
// start bit on MISO, then shifts in an R1 response MSB-first.
module sd_response
  import sd_pkg::*;
#(
  parameter int RESP_BITS = R1_BITS,
  parameter int NCR_MAX   = NCR_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  sd_response_if.slave  bus
);

  localparam int WAIT_W = (NCR_MAX > 1) ? $clog2(NCR_MAX) : 1;
  localparam int BIT_W  = $clog2(RESP_BITS);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(NCR_MAX - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(RESP_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_FIRST = BIT_W'(1);

  sd_state_t              state;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  // The start bit is implied (always 0), so only RESP_BITS-1 bits are held.
  logic [RESP_BITS-2:0]   shreg;
  logic [RESP_BITS-1:0]   resp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      resp_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flag) begin
            state    <= WAIT_START;
            wait_cnt <= '0;
          end
        end
        WAIT_START: begin
          if (!bus.response) begin
            shreg   <= '0;
            bit_cnt <= BIT_FIRST;
            state   <= RECEIVE;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RECEIVE: begin
          shreg   <= {shreg[RESP_BITS-3:0], bus.response};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            resp_data_q <= {shreg, bus.response};
            state       <= DONE;
          end
        end
        DONE, TIMEOUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.receive_state = (state == RECEIVE);
  assign bus.resp_valid    = (state == DONE);
  assign bus.resp_timeout  = (state == TIMEOUT);
  assign bus.resp_data     = resp_data_q;

endmodule

// File: tb/tb_sd_response.sv
// Randomized bench for sd_response: predicts each reception from the line
// waveform (first 0 within the NCR window, then the next bits MSB-first).
module tb_sd_response;

  localparam int RB  = 8;
  localparam int NCR = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sd_response_if #(.RESP_BITS(RB)) bus ();

  sd_response #(
    .RESP_BITS (RB),
    .NCR_MAX   (NCR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [RB-1:0] model_data = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] statusBits();
    return 32'({bus.receive_state, bus.resp_valid, bus.resp_timeout});
  endfunction

  // Status encoding used in checks: {receive_state, resp_valid, resp_timeout}.
  task automatic checkState(input string tag, input bit rs, input bit v, input bit to);
    checkOutput({tag, "_status"}, statusBits(), 32'({rs, v, to}));
    checkOutput({tag, "_data"}, 32'(bus.resp_data), 32'(model_data));
  endtask

  // One armed reception: lead_ones idle-high samples, then data MSB-first,
  // then the line idles high. abort_after >= 0 asserts rst after that many
  // RECEIVE cycles past the first.
  task automatic applyStimulus(input string tag, input logic [RB-1:0] data,
                               input int lead_ones, input bit rand_flag,
                               input int abort_after);
    bit            line[$];
    int            k;
    int            last;
    logic [RB-1:0] exp_data;
    bit            exp_rs, exp_v, exp_to;

    for (int i = 0; i < lead_ones; i++) line.push_back(1'b1);
    for (int j = RB - 1; j >= 0; j--) line.push_back(data[j]);
    while (line.size() < lead_ones + NCR + RB + 4) line.push_back(1'b1);

    k = -1;
    for (int i = 0; i < NCR; i++) begin
      if (line[i] == 1'b0) begin
        k = i;
        break;
      end
    end
    exp_data = '0;
    if (k >= 0)
      for (int j = 0; j < RB; j++) exp_data = {exp_data[RB-2:0], line[k+j]};
    last = (k < 0) ? NCR : k + RB;

    bus.flag     = 1'b1;
    bus.response = 1'($urandom);
    stepCycle();
    checkState({tag, "_armed"}, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i <= last; i++) begin
      bus.response = line[i];
      bus.flag     = rand_flag ? 1'($urandom) : 1'b0;
      stepCycle();
      exp_rs = (k >= 0) && (i >= k) && (i < k + RB - 1);
      exp_v  = (k >= 0) && (i == k + RB - 1);
      exp_to = (k < 0) && (i == NCR - 1);
      if (exp_v) model_data = exp_data;
      checkState(tag, exp_rs, exp_v, exp_to);
      if (abort_after >= 0 && k >= 0 && i == k + abort_after) begin
        rst      = 1'b1;
        bus.flag = 1'($urandom);
        stepCycle();
        rst        = 1'b0;
        bus.flag   = 1'b0;
        model_data = '0;
        checkState({tag, "_reset"}, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkState({tag, "_after_reset"}, 1'b0, 1'b0, 1'b0);
        return;
      end
    end
    bus.flag = 1'b0;
    stepCycle();
    checkState({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.flag     = 1'b0;
    bus.response = 1'b1;
    rst          = 1'b1;

    for (int c = 0; c < 2; c++) begin
      stepCycle();
      checkState("reset", 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.response = 1'($urandom);
      stepCycle();
      checkState("idle_hold", 1'b0, 1'b0, 1'b0);
    end

    // Continuous zero line with flag held: a frame every 10 cycles.
    bus.flag     = 1'b1;
    bus.response = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      int p;
      stepCycle();
      p = (c - 1) % 10;
      checkState("stream", (p >= 1 && p <= 7), (p == 8), 1'b0);
    end
    bus.flag = 1'b0;
    bus.response = 1'b1;
    stepCycle();
    checkState("stream_end", 1'b0, 1'b0, 1'b0);

    applyStimulus("idle_r1", 8'h01, 3, 1'b0, -1);
    applyStimulus("timeout", 8'h00, NCR, 1'b0, -1);
    applyStimulus("late_start", 8'h05, NCR - 1, 1'b0, -1);
    applyStimulus("first_sample", 8'h7F, 0, 1'b1, -1);

    for (int n = 0; n < 10; n++) begin
      logic [RB-1:0] d;
      d = RB'($urandom);
      d[RB-1] = 1'b0;
      applyStimulus("random", d, int'($urandom_range(0, 20)), 1'b1, -1);
    end

    applyStimulus("abort", 8'h3C, 2, 1'b1, 3);
    applyStimulus("post_abort", 8'h5A, 1, 1'b1, -1);
    applyStimulus("timeout2", 8'h00, NCR + 5, 1'b1, -1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
